// File: rtl/kbest_sorter_if.sv
// Candidate-in / sorted-frame-out bundle for the K-best sorter.
// master = upstream/downstream side, slave = the sorter itself.
interface kbest_sorter_if #(
  parameter int K      = 4,
  parameter int ED_W   = 32,
  parameter int NODE_W = 16
);
  localparam int CNT_W = $clog2(K + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [ED_W-1:0]       in_ed;
  logic [NODE_W-1:0]     in_node;
  logic                  out_valid;
  logic                  out_ready;
  logic [K*ED_W-1:0]     out_ed;
  logic [K*NODE_W-1:0]   out_node;
  logic [CNT_W-1:0]      out_count;

  modport master (
    output in_valid, in_last, in_ed, in_node, out_ready,
    input  in_ready, out_valid, out_ed, out_node, out_count
  );

  modport slave (
    input  in_valid, in_last, in_ed, in_node, out_ready,
    output in_ready, out_valid, out_ed, out_node, out_count
  );
endinterface

// File: rtl/kbest_sorter.sv
// Streaming K-best sorter: keeps the K smallest (ED, node) pairs of a frame in
// ascending order with stable ties, then holds the list until downstream takes it.
module kbest_sorter #(
  parameter int K      = 4,
  parameter int ED_W   = 32,
  parameter int NODE_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  kbest_sorter_if.slave bus
);
  localparam int CNT_W = $clog2(K + 1);

  typedef enum logic {COLLECT, OUTPUT} state_t;

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    count;
  logic [ED_W-1:0]     slot_ed   [K];
  logic [NODE_W-1:0]   slot_node [K];
  logic [K-1:0]        slot_vld;

  logic [K-1:0]        keep;      // slot holds a valid ED <= candidate, so it stays put
  logic [K-1:0]        ins_here;  // first slot that does not stay: candidate lands here
  logic                accept;
  logic                release_out;

  assign accept      = bus.in_valid && in_ready_q;
  assign release_out = (state == OUTPUT) && bus.out_ready;

  // Slots are sorted with valid entries packed at the bottom, so keep[] is a
  // thermometer code and its first zero is the insertion point p.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    keep     = '0;
    ins_here = '0;
    for (int i = 0; i < K; i++) begin
      keep[i] = slot_vld[i] && (slot_ed[i] <= bus.in_ed);
    end
    ins_here[0] = !keep[0];
    for (int i = 1; i < K; i++) begin
      ins_here[i] = !keep[i] && keep[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader
  // in this block sees the pre-edge values of the slots it shifts from.
  always_ff @(posedge clk) begin
    if (rst || release_out) begin
      state       <= COLLECT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count       <= '0;
      slot_vld    <= '0;
      // NOTE: the slot arrays are reset on purpose: empty slots are visible on
      // the outputs as ED all-ones / node 0, and validity gates the compare.
      for (int i = 0; i < K; i++) begin
        slot_ed[i]   <= '1;
        slot_node[i] <= '0;
      end
    end else if (state == COLLECT && accept) begin
      if (ins_here[0]) begin
        slot_ed[0]   <= bus.in_ed;
        slot_node[0] <= bus.in_node;
        slot_vld[0]  <= 1'b1;
      end
      for (int i = 1; i < K; i++) begin
        if (ins_here[i]) begin
          slot_ed[i]   <= bus.in_ed;
          slot_node[i] <= bus.in_node;
          slot_vld[i]  <= 1'b1;
        end else if (!keep[i]) begin
          slot_ed[i]   <= slot_ed[i-1];
          slot_node[i] <= slot_node[i-1];
          slot_vld[i]  <= slot_vld[i-1];
        end
      end
      count <= (count == CNT_W'(K)) ? count : count + CNT_W'(1);
      if (bus.in_last) begin
        state       <= OUTPUT;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = count;

  for (genvar g = 0; g < K; g++) begin : g_pack
    assign bus.out_ed[g*ED_W +: ED_W]       = slot_ed[g];
    assign bus.out_node[g*NODE_W +: NODE_W] = slot_node[g];
  end
endmodule

// File: tb/tb_kbest_sorter.sv
// Bench for kbest_sorter: directed frames from the test plan plus random frames
// checked against a queue-based sort-and-truncate model.
module tb_kbest_sorter;
  localparam int K      = 4;
  localparam int ED_W   = 32;
  localparam int NODE_W = 16;
  localparam int CNT_W  = $clog2(K + 1);
  localparam logic [ED_W-1:0] ED_MAX = '1;

  typedef struct {
    logic [ED_W-1:0]   ed;
    logic [NODE_W-1:0] node;
  } cand_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [ED_W-1:0]   fr_ed[$];
  logic [NODE_W-1:0] fr_node[$];
  logic [ED_W-1:0]   exp_ed[K];
  logic [NODE_W-1:0] exp_node[K];
  int                exp_cnt;

  kbest_sorter_if #(.K(K), .ED_W(ED_W), .NODE_W(NODE_W)) bus ();

  kbest_sorter #(.K(K), .ED_W(ED_W), .NODE_W(NODE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: insert each candidate after all equal-or-smaller EDs, drop beyond K.
  task automatic model_frame();
    cand_t kept[$];
    for (int n = 0; n < fr_ed.size(); n++) begin
      int pos = kept.size();
      for (int j = 0; j < kept.size(); j++) begin
        if (kept[j].ed > fr_ed[n]) begin
          pos = j;
          break;
        end
      end
      kept.insert(pos, '{fr_ed[n], fr_node[n]});
      if (kept.size() > K) void'(kept.pop_back());
    end
    exp_cnt = kept.size();
    for (int i = 0; i < K; i++) begin
      exp_ed[i]   = (i < kept.size()) ? kept[i].ed   : ED_MAX;
      exp_node[i] = (i < kept.size()) ? kept[i].node : '0;
    end
  endtask

  task automatic send_frame(input bit with_last, input bit gaps);
    for (int n = 0; n < fr_ed.size(); n++) begin
      int waits = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      if (waits >= 50) begin
        total++; bad++;
        $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, waits);
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_ed    = fr_ed[n];
      bus.in_node  = fr_node[n];
      bus.in_last  = with_last && (n == fr_ed.size() - 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_last = 0; bus.in_ed = '0; bus.in_node = '0; bus.out_ready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.out_count); end
    for (int i = 0; i < K; i++) begin
      total++;
      if (bus.out_ed[i*ED_W +: ED_W] !== ED_MAX || bus.out_node[i*NODE_W +: NODE_W] !== '0) begin
        bad++;
        $display("FAIL reset_slot%0d: got ed=%0h node=%0d want ed=%0h node=0", i,
                 bus.out_ed[i*ED_W +: ED_W], bus.out_node[i*NODE_W +: NODE_W], ED_MAX);
      end
    end
  endtask

  task automatic test_basic();
    fr_ed   = '{9, 3, 7, 1, 5, 8};
    fr_node = '{0, 1, 2, 3, 4, 5};
    exp_ed  = '{1, 3, 5, 7};
    exp_node = '{3, 1, 4, 2};
    send_frame(1'b1, 1'b0);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_count !== CNT_W'(4)) begin bad++; $display("FAIL basic_count: got %0d want 4", bus.out_count); end
    for (int i = 0; i < K; i++) begin
      total++;
      if (bus.out_ed[i*ED_W +: ED_W] !== exp_ed[i] || bus.out_node[i*NODE_W +: NODE_W] !== exp_node[i]) begin
        bad++;
        $display("FAIL basic_slot%0d: got ed=%0h node=%0d want ed=%0h node=%0d", i,
                 bus.out_ed[i*ED_W +: ED_W], bus.out_node[i*NODE_W +: NODE_W], exp_ed[i], exp_node[i]);
      end
    end
    drain();
  endtask

  task automatic test_ties();
    fr_ed    = '{4, 4, 2, 4, 4};
    fr_node  = '{10, 11, 12, 13, 14};
    exp_ed   = '{2, 4, 4, 4};
    exp_node = '{12, 10, 11, 13};
    send_frame(1'b1, 1'b0);
    @(negedge clk);
    total++; if (bus.out_count !== CNT_W'(4)) begin bad++; $display("FAIL ties_count: got %0d want 4", bus.out_count); end
    for (int i = 0; i < K; i++) begin
      total++;
      if (bus.out_ed[i*ED_W +: ED_W] !== exp_ed[i] || bus.out_node[i*NODE_W +: NODE_W] !== exp_node[i]) begin
        bad++;
        $display("FAIL ties_slot%0d: got ed=%0h node=%0d want ed=%0h node=%0d", i,
                 bus.out_ed[i*ED_W +: ED_W], bus.out_node[i*NODE_W +: NODE_W], exp_ed[i], exp_node[i]);
      end
    end
    drain();
  endtask

  task automatic test_short();
    // Short frame, then a frame whose first candidate is all-ones.
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        fr_ed = '{6, 2}; fr_node = '{1, 2};
        exp_ed = '{2, 6, ED_MAX, ED_MAX}; exp_node = '{2, 1, 0, 0};
      end else begin
        fr_ed = '{ED_MAX, 3}; fr_node = '{9, 8};
        exp_ed = '{3, ED_MAX, ED_MAX, ED_MAX}; exp_node = '{8, 9, 0, 0};
      end
      send_frame(1'b1, 1'b0);
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL short%0d_valid: got %b want 1", f, bus.out_valid); end
      total++; if (bus.out_count !== CNT_W'(2)) begin bad++; $display("FAIL short%0d_count: got %0d want 2", f, bus.out_count); end
      for (int i = 0; i < K; i++) begin
        total++;
        if (bus.out_ed[i*ED_W +: ED_W] !== exp_ed[i] || bus.out_node[i*NODE_W +: NODE_W] !== exp_node[i]) begin
          bad++;
          $display("FAIL short%0d_slot%0d: got ed=%0h node=%0d want ed=%0h node=%0d", f, i,
                   bus.out_ed[i*ED_W +: ED_W], bus.out_node[i*NODE_W +: NODE_W], exp_ed[i], exp_node[i]);
        end
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    fr_ed.delete(); fr_node.delete();
    for (int n = 0; n < 5; n++) begin
      fr_ed.push_back(ED_W'($urandom_range(10, 60)));
      fr_node.push_back(NODE_W'($urandom));
    end
    model_frame();
    send_frame(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_ed = '0; bus.in_node = NODE_W'(c + 100); bus.in_last = c[0];
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin bad++;
        $display("FAIL hold%0d_handshake: got in_ready=%b out_valid=%b want 0/1", c, bus.in_ready, bus.out_valid); end
      total++; if (bus.out_count !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL hold%0d_count: got %0d want %0d", c, bus.out_count, exp_cnt); end
      for (int i = 0; i < K; i++) begin
        total++;
        if (bus.out_ed[i*ED_W +: ED_W] !== exp_ed[i] || bus.out_node[i*NODE_W +: NODE_W] !== exp_node[i]) begin
          bad++;
          $display("FAIL hold%0d_slot%0d: got ed=%0h node=%0d want ed=%0h node=%0d", c, i,
                   bus.out_ed[i*ED_W +: ED_W], bus.out_node[i*NODE_W +: NODE_W], exp_ed[i], exp_node[i]);
        end
      end
    end
    drain();
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL release_handshake: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    total++; if (bus.out_count !== '0 || bus.out_ed[0 +: ED_W] !== ED_MAX) begin bad++;
      $display("FAIL release_cleared: got count=%0d ed0=%0h want 0/%0h", bus.out_count, bus.out_ed[0 +: ED_W], ED_MAX); end
  endtask

  task automatic test_reset_mid();
    fr_ed = '{20, 1, 30}; fr_node = '{1, 2, 3};
    send_frame(1'b0, 1'b0);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midframe_valid: got %b want 0", bus.out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== '0) begin bad++;
      $display("FAIL midreset_state: got out_valid=%b in_ready=%b count=%0d want 0/1/0", bus.out_valid, bus.in_ready, bus.out_count); end
    total++; if (bus.out_ed[0 +: ED_W] !== ED_MAX) begin bad++; $display("FAIL midreset_slot0: got ed=%0h want %0h", bus.out_ed[0 +: ED_W], ED_MAX); end
    fr_ed = '{5}; fr_node = '{7};
    exp_ed = '{5, ED_MAX, ED_MAX, ED_MAX}; exp_node = '{7, 0, 0, 0};
    send_frame(1'b1, 1'b0);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_count !== CNT_W'(1)) begin bad++;
      $display("FAIL single_frame: got out_valid=%b count=%0d want 1/1", bus.out_valid, bus.out_count); end
    for (int i = 0; i < K; i++) begin
      total++;
      if (bus.out_ed[i*ED_W +: ED_W] !== exp_ed[i] || bus.out_node[i*NODE_W +: NODE_W] !== exp_node[i]) begin
        bad++;
        $display("FAIL single_slot%0d: got ed=%0h node=%0d want ed=%0h node=%0d", i,
                 bus.out_ed[i*ED_W +: ED_W], bus.out_node[i*NODE_W +: NODE_W], exp_ed[i], exp_node[i]);
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, 7);
      fr_ed.delete(); fr_node.delete();
      for (int n = 0; n < len; n++) begin
        case ($urandom_range(0, 3))
          0, 1:    fr_ed.push_back(ED_W'($urandom_range(0, 7)));
          2:       fr_ed.push_back(ED_MAX);
          default: fr_ed.push_back(ED_W'($urandom));
        endcase
        fr_node.push_back(NODE_W'($urandom));
      end
      // out_ready pulsed while idle must not disturb the next frame.
      if (f[0]) begin
        @(negedge clk); bus.out_ready = 1'b1;
        @(negedge clk); bus.out_ready = 1'b0;
      end
      model_frame();
      send_frame(1'b1, 1'b1);
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_count !== CNT_W'(exp_cnt)) begin bad++;
        $display("FAIL rand%0d_status: got out_valid=%b count=%0d want 1/%0d", f, bus.out_valid, bus.out_count, exp_cnt); end
      for (int i = 0; i < K; i++) begin
        total++;
        if (bus.out_ed[i*ED_W +: ED_W] !== exp_ed[i] || bus.out_node[i*NODE_W +: NODE_W] !== exp_node[i]) begin
          bad++;
          $display("FAIL rand%0d_slot%0d: got ed=%0h node=%0d want ed=%0h node=%0d", f, i,
                   bus.out_ed[i*ED_W +: ED_W], bus.out_node[i*NODE_W +: NODE_W], exp_ed[i], exp_node[i]);
        end
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_short();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/kbest_sorter.md
Name: kbest_sorter

Overview:
- Parametrised successor to the two-minimum finder in the detector datapath.
- Streams (ED, node) candidates for one tree level/frame and keeps the K smallest EDs in ascending order.
- Tie order is stable. Frame boundaries are explicit and handshaking is valid/ready.
- Feeds the K surviving nodes to the next K-best expansion stage.

Parameters:
- K, 4, number of survivors kept; K >= 2.
- ED_W, 32, ED width; unsigned.
- NODE_W, 16, node index width.
- CNT_W, $clog2(K+1), width of out_count; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  candidate present.
- in_ready  out  1  block accepts a candidate this cycle.
- in_last  in  1  candidate is the final one of the frame.
- in_ed  in  ED_W  candidate Euclidean distance, unsigned.
- in_node  in  NODE_W  candidate node index.
- out_valid  out  1  sorted result frame available.
- out_ready  in  1  downstream takes the result.
- out_ed  out  K*ED_W  slot i at bits [i*ED_W +: ED_W]; slot 0 is the smallest.
- out_node  out  K*NODE_W  node for slot i, same packing.
- out_count  out  CNT_W  number of valid slots, 1..K when out_valid is high.

Behaviour:

Reset:
- State COLLECT. in_ready=1, out_valid=0, out_count=0.
- All slot EDs = all-ones, all slot nodes = 0, all slot valid flags = 0.
- rst overrides everything, including mid-frame and while holding output. The partial frame is discarded and no output is produced for it.

States and transitions:
- COLLECT: in_ready=1, out_valid=0.
- Accept = in_valid && in_ready. Each accept performs one insertion.
- Accept with in_last=1 moves to OUTPUT on the next edge.
- OUTPUT: in_ready=0, out_valid=1; out_ed, out_node and out_count are held stable.
- When out_valid && out_ready, clear all slots (as at reset), set count=0 and return to COLLECT.
- There is exactly one bubble cycle before the next frame's first accept.

Latency:
- out_valid rises on the edge that follows the accepted in_last beat.
- Result includes the in_last candidate.

Insertion, single cycle:
- p = number of valid slots with ED <= in_ed, using an unsigned compare.
- Stable tie: a new candidate with an equal ED goes after existing equals, so the earliest arrival wins.
- If p < K:
  - slots p..K-2 shift to p+1..K-1;
  - the old slot K-1 is dropped;
  - the candidate is written at slot p and marked valid.
- If p == K, the candidate is discarded.
- count = min(count+1, K).

Boundary conditions:
- Invalid slots never compare as smaller. A candidate with ED = all-ones is inserted if count < K.
- Frame shorter than K: out_count < K. Unused slots show ED all-ones, node 0.
- Single-candidate frame (in_valid and in_last on the first beat): out_count=1.
- in_valid while in_ready=0: ignored, not buffered. Upstream must hold the candidate.
- out_ready while out_valid=0: no effect.
- No wrap or overflow is possible: count saturates at K, and EDs are not modified.

Outputs:
- Registered, driven directly from slot registers.
- In COLLECT they show the partial list and are don't-care to downstream.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, out_count=0, all out_ed slots = 0xFFFFFFFF.
- K=4; EDs 9,3,7,1,5,8 (nodes 0..5), last on node 5 -> one cycle later out_valid=1, out_ed=1,3,5,7, out_node=3,1,4,2, out_count=4.
- Ties: EDs 4(n10),4(n11),2(n12),4(n13),4(n14, last) -> out_ed=2,4,4,4, out_node=12,10,11,13; n14 is dropped.
- Short frame: EDs 6(n1),2(n2, last) -> out_count=2, out_ed=2,6,FFFFFFFF,FFFFFFFF, out_node=2,1,0,0.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid -> outputs stable, in_ready=0, nothing inserted. Then out_ready=1 -> next cycle in_ready=1 and count=0. The following frame is sorted independently.
- Reset mid-frame after 3 accepts: next cycle cleared state, no out_valid. A new frame 5(n7, last) -> out_count=1, out_ed[0]=5, out_node[0]=7.
